// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG post-processing slice.
// The level-width helper keeps FIFO and top port widths in agreement.
package trng_pkg;

    localparam int TRNG_BYTE_W = 8;

    typedef enum logic {
        PAIR_EMPTY = 1'b0,
        PAIR_FIRST = 1'b1
    } pair_state_e;

    function automatic int trng_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trng_fifo.sv
// Synchronous show-ahead FIFO: rdata is the head entry whenever empty is low.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module trng_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        empty    = (level_q == '0);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
        rdata = mem_q[rd_ptr_q];
        level = level_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/trng_conditioner.sv
// TRNG conditioner: repetition-count health test on the raw stream, von Neumann
// debiasing, LSB-first byte packing and a show-ahead output FIFO with sticky flags.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RCT_LIMIT  = 32,
    parameter int ENABLE_VN  = 1
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  raw_bit,
    input  logic                                  raw_valid,
    output logic [TRNG_BYTE_W-1:0]                dout,
    output logic                                  dout_valid,
    input  logic                                  dout_ready,
    input  logic                                  clear_alarm,
    output logic                                  rct_alarm,
    output logic                                  overflow,
    output logic [trng_level_w(FIFO_DEPTH)-1:0]   fifo_level
);

    localparam int RCT_W = $clog2(RCT_LIMIT + 1);
    localparam int PK_W  = $clog2(TRNG_BYTE_W);

    logic                   rct_seen_q, rct_seen_d;
    logic                   rct_prev_q, rct_prev_d;
    logic [RCT_W-1:0]       rct_cnt_q, rct_cnt_d;
    logic                   rct_hit;
    pair_state_e            pair_q, pair_d;
    logic                   first_q, first_d;
    logic                   emit_vld, emit_bit;
    logic [PK_W-1:0]        pk_cnt_q, pk_cnt_d;
    logic [TRNG_BYTE_W-1:0] shreg_q, shreg_d;
    logic [TRNG_BYTE_W-1:0] hold_q, hold_d;
    logic                   pend_q, pend_d;
    logic                   alarm_q, alarm_d;
    logic                   ovf_q, ovf_d;
    logic                   fifo_full, fifo_empty, pop;
    logic [TRNG_BYTE_W-1:0] fifo_rdata;

    trng_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (TRNG_BYTE_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (pend_q),
        .wdata  (hold_q),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_comb begin
        rct_seen_d = rct_seen_q;
        rct_prev_d = rct_prev_q;
        rct_cnt_d  = rct_cnt_q;
        rct_hit    = 1'b0;
        if (raw_valid) begin
            rct_seen_d = 1'b1;
            rct_prev_d = raw_bit;
            if (!rct_seen_q || (raw_bit != rct_prev_q)) begin
                rct_cnt_d = RCT_W'(1);
            end else if (rct_cnt_q != RCT_W'(RCT_LIMIT)) begin
                rct_cnt_d = rct_cnt_q + RCT_W'(1);
            end
            rct_hit = (rct_cnt_d == RCT_W'(RCT_LIMIT));
        end

        // Pair stage is frozen empty while the health alarm stands.
        pair_d   = pair_q;
        first_d  = first_q;
        emit_vld = 1'b0;
        emit_bit = 1'b0;
        if (alarm_q) begin
            pair_d = PAIR_EMPTY;
        end else if (raw_valid) begin
            if (ENABLE_VN == 0) begin
                emit_vld = 1'b1;
                emit_bit = raw_bit;
            end else if (pair_q == PAIR_EMPTY) begin
                first_d = raw_bit;
                pair_d  = PAIR_FIRST;
            end else begin
                pair_d = PAIR_EMPTY;
                if (raw_bit != first_q) begin
                    emit_vld = 1'b1;
                    emit_bit = first_q;
                end
            end
        end

        pk_cnt_d = pk_cnt_q;
        shreg_d  = shreg_q;
        hold_d   = hold_q;
        pend_d   = 1'b0;
        if (alarm_q) begin
            pk_cnt_d = '0;
        end else if (emit_vld) begin
            shreg_d[pk_cnt_q] = emit_bit;
            if (pk_cnt_q == PK_W'(TRNG_BYTE_W - 1)) begin
                hold_d   = shreg_d;
                pend_d   = 1'b1;
                pk_cnt_d = '0;
            end else begin
                pk_cnt_d = pk_cnt_q + PK_W'(1);
            end
        end

        // A set event on the same edge as clear_alarm keeps the flag high.
        dout_valid = !fifo_empty;
        dout       = dout_valid ? fifo_rdata : '0;
        pop        = dout_valid && dout_ready;
        alarm_d    = rct_hit || (alarm_q && !clear_alarm);
        ovf_d      = (pend_q && fifo_full && !pop) || (ovf_q && !clear_alarm);
        rct_alarm  = alarm_q;
        overflow   = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rct_seen_q <= 1'b0;
            rct_cnt_q  <= '0;
            pair_q     <= PAIR_EMPTY;
            pk_cnt_q   <= '0;
            pend_q     <= 1'b0;
            alarm_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rct_seen_q <= rct_seen_d;
            rct_cnt_q  <= rct_cnt_d;
            pair_q     <= pair_d;
            pk_cnt_q   <= pk_cnt_d;
            pend_q     <= pend_d;
            alarm_q    <= alarm_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        rct_prev_q <= rct_prev_d;
        first_q    <= first_d;
        shreg_q    <= shreg_d;
        hold_q     <= hold_d;
    end

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: von Neumann packing, health alarm,
// FIFO overflow/full-with-pop and mid-operation reset.
module tb_trng_conditioner;

    logic       clk;
    logic       resetn;
    logic       raw_bit;
    logic       raw_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       clear_alarm;
    logic       rct_alarm;
    logic       overflow;
    logic [3:0] fifo_level;

    int total = 0;
    int bad   = 0;

    trng_conditioner #(
        .FIFO_DEPTH (8),
        .RCT_LIMIT  (32),
        .ENABLE_VN  (1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .clear_alarm (clear_alarm),
        .rct_alarm   (rct_alarm),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        tick();
        raw_valid = 1'b0;
    endtask

    // Each corrected bit is produced by a 10 (gives 1) or 01 (gives 0) raw pair.
    task automatic send_vn_bits(input logic [7:0] value, input int n);
        for (int i = 0; i < n; i++) begin
            if (value[i]) begin
                send(1'b1);
                send(1'b0);
            end else begin
                send(1'b0);
                send(1'b1);
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        resetn      = 1'b0;
        raw_bit     = 1'b0;
        raw_valid   = 1'b0;
        dout_ready  = 1'b1;
        clear_alarm = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_alarm", 32'(rct_alarm), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);

        // Alternating 10/01 pairs give bits 1,0,1,0,... -> 8'h55.
        send_vn_bits(8'h55, 8);
        check("b55_not_yet", 32'(dout_valid), 32'h0);
        tick();
        check("b55_valid", 32'(dout_valid), 32'h1);
        check("b55_dout", 32'(dout), 32'h55);
        check("b55_level", 32'(fifo_level), 32'h1);
        tick();
        check("b55_gone", 32'(dout_valid), 32'h0);
        check("b55_level0", 32'(fifo_level), 32'h0);

        // 11/00 pairs are discarded; runs never exceed two.
        for (int i = 0; i < 10; i++) begin
            send(1'b1); send(1'b1); send(1'b0); send(1'b0);
        end
        tick();
        check("eq_valid", 32'(dout_valid), 32'h0);
        check("eq_level", 32'(fifo_level), 32'h0);
        check("eq_alarm", 32'(rct_alarm), 32'h0);

        // 32 identical raw bits trip the health test on the 32nd.
        for (int i = 0; i < 31; i++) send(1'b1);
        check("rct_31", 32'(rct_alarm), 32'h0);
        send(1'b1);
        check("rct_32", 32'(rct_alarm), 32'h1);
        send_vn_bits(8'hA5, 8);
        tick();
        check("alarm_nobyte", 32'(dout_valid), 32'h0);
        check("alarm_level", 32'(fifo_level), 32'h0);
        check("alarm_held", 32'(rct_alarm), 32'h1);
        clear_alarm = 1'b1;
        tick();
        clear_alarm = 1'b0;
        check("alarm_clr", 32'(rct_alarm), 32'h0);
        send_vn_bits(8'h3C, 8);
        tick();
        check("post_clr_valid", 32'(dout_valid), 32'h1);
        check("post_clr_dout", 32'(dout), 32'h3C);
        tick();
        check("post_clr_gone", 32'(dout_valid), 32'h0);

        // Nine bytes into an eight-deep FIFO with no consumer.
        dout_ready = 1'b0;
        for (int k = 0; k < 9; k++) send_vn_bits(8'(k), 8);
        tick();
        check("ovf_level", 32'(fifo_level), 32'h8);
        check("ovf_flag", 32'(overflow), 32'h1);
        dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf_dout%0d", k), 32'(dout), 32'(k));
            tick();
        end
        check("ovf_drained", 32'(dout_valid), 32'h0);
        check("ovf_level0", 32'(fifo_level), 32'h0);
        clear_alarm = 1'b1;
        tick();
        clear_alarm = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);

        // Full FIFO: the push edge of byte 0x18 also pops, so nothing is lost.
        dout_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_vn_bits(8'(8'h10 + k), 8);
        tick();
        check("full_level", 32'(fifo_level), 32'h8);
        send_vn_bits(8'h18, 8);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("fullpop_level", 32'(fifo_level), 32'h8);
        check("fullpop_ovf", 32'(overflow), 32'h0);
        check("fullpop_head", 32'(dout), 32'h11);
        dout_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            check($sformatf("fullpop_dout%0d", k), 32'(dout), 32'(8'h10 + k));
            tick();
        end
        check("fullpop_empty", 32'(fifo_level), 32'h0);

        // Reset with a byte queued and five corrected bits in the packer.
        dout_ready = 1'b0;
        send_vn_bits(8'h77, 8);
        send_vn_bits(8'hFF, 5);
        tick();
        check("prerst_level", 32'(fifo_level), 32'h1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_dout", 32'(dout), 32'h0);
        check("midrst_valid", 32'(dout_valid), 32'h0);
        check("midrst_level", 32'(fifo_level), 32'h0);
        check("midrst_flags", 32'({rct_alarm, overflow}), 32'h0);
        b = 8'hC0;
        send_vn_bits(b, 7);
        tick();
        check("midrst_partial", 32'(dout_valid), 32'h0);
        send_vn_bits(8'h01, 1);
        tick();
        check("midrst_byte_valid", 32'(dout_valid), 32'h1);
        check("midrst_byte", 32'(dout), 32'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trng_conditioner.md
# trng_conditioner

Post-processing stage fed directly by the TRNG sampler: it consumes the raw per-period random bit and its strobe, runs a repetition-count health test on the raw stream, removes bias with a von Neumann corrector, and packs the corrected bits into bytes. Bytes go into a small show-ahead FIFO drained by a valid/ready consumer (bus register or UART feeder). Sticky status flags report health failure and FIFO overflow.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `RCT_LIMIT`, 32: consecutive identical raw samples that trip the health alarm; ≥2.
- `ENABLE_VN`, 1: 1 = von Neumann correction on; 0 = every raw bit passes to the packer.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `raw_bit` in 1: raw random sample from the sampler.
- `raw_valid` in 1: one-cycle strobe; `raw_bit` is sampled on the edge where it is high.
- `dout` out 8: FIFO head byte.
- `dout_valid` out 1: FIFO non-empty.
- `dout_ready` in 1: consumer accepts `dout` on the edge where `dout_valid && dout_ready`.
- `clear_alarm` in 1: one-cycle pulse; clears `rct_alarm` and `overflow`.
- `rct_alarm` out 1: sticky repetition-count failure.
- `overflow` out 1: sticky; a completed byte was dropped because the FIFO was full.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current entry count.

## Operation

- Reset: all outputs 0; FIFO empty; pair stage EMPTY; packer count 0; RCT count 0.
- RCT (raw stream, before correction): counter width $clog2(RCT_LIMIT+1), saturating. On each `raw_valid`: count = 1 if first sample after reset or bit differs from the previous raw bit, else count+1 (saturating at RCT_LIMIT). Set `rct_alarm` on the edge where the new count reaches RCT_LIMIT.
- `clear_alarm` clears both flags; a set event on the same edge wins (flag stays 1). With the count saturated, the next identical sample sets the alarm again.
- While `rct_alarm`=1: raw bits still feed the RCT, but the pair stage is held in EMPTY and the packer is cleared (partial byte discarded). The FIFO still drains.
- Pair stage, ENABLE_VN=1, two states:
  - EMPTY: on `raw_valid`, store the bit → FIRST.
  - FIRST: on `raw_valid`, pair 01 emits 0, pair 10 emits 1, pairs 00/11 emit nothing; → EMPTY.
- Pair stage, ENABLE_VN=0: each `raw_valid` emits `raw_bit`.
- Packer: first emitted bit lands in bit 0 (LSB-first). On the 8th bit the byte is latched into a one-entry holding register with a pending flag, and the count returns to 0.
- FIFO push: a pending byte is pushed on the next edge. If the FIFO is full and no pop occurs on that edge, the byte is dropped and `overflow` is set.
- Simultaneous push and pop on a full FIFO: both happen; level stays at FIFO_DEPTH; no overflow.
- Pop: on `dout_valid && dout_ready`; `dout` is the next entry on the following cycle. `dout` holds its value while not popped; contents are don't-care when empty.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. `fifo_level` = pushes − pops, range 0..FIFO_DEPTH.

## Timing

- RCT and alarm: `rct_alarm` is high after the edge that samples the RCT_LIMIT-th identical raw bit.
- Byte latency: edge E samples the completing `raw_valid`, edge E+1 writes the FIFO, and `dout_valid`/`fifo_level` update after E+1.
- Pop: `fifo_level` decrements after the accepting edge. Throughput is one byte per cycle.
- Reset mid-operation (resetn low for ≥1 edge): partial byte, pending byte, FIFO contents, RCT history and flags are all discarded; outputs are 0 from the next cycle.

## Structure

- Package `trng_pkg`:
  - `TRNG_BYTE_W` = 8.
  - Pair-stage enum {PAIR_EMPTY, PAIR_FIRST}.
  - Function returning the level width for a given depth.
- Sub-module `trng_fifo`: synchronous show-ahead FIFO with push/pop, full/empty and level; parameterised by depth and width.
- Top: RCT, pair stage, packer and flag logic.

## Test plan

- Alternating raw pairs 1,0 / 0,1 repeated ×8 (16 raw bits, `dout_ready`=1): one byte `dout`=8'h55; `dout_valid` high for exactly one cycle, two edges after the last strobe.
- 40 raw bits as pairs 0,0 / 1,1 alternating: no `dout_valid`, `fifo_level` stays 0, `rct_alarm` stays 0.
- 32 consecutive raw 1s: `rct_alarm` rises after the 32nd strobe.
  - Then feed 16 valid 10/01 pairs: no bytes while the alarm is set.
  - Pulse `clear_alarm`: flag clears; the next 16 valid bits yield one byte.
- `dout_ready`=0, FIFO_DEPTH=8, generate 9 bytes 8'h00..8'h08: `fifo_level`=8, `overflow`=1; raise `dout_ready` → 8'h00..8'h07 emerge in order and 8'h08 is absent.
- FIFO full, a byte completes on the same edge `dout_ready`=1 pops: level stays 8, `overflow` stays 0, new byte appears last.
- 5 corrected bits, then `resetn` low for one edge: outputs 0. The next 8 corrected bits form a byte containing only post-reset bits.
